// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
//
// Receive-side checker for a loadable up/down counter. Each cycle that
// `sample` is high, the observed `count` is compared against the last
// sampled value. The transition is classified as a hold, an up-step, a
// down-step or a jump. The block reports wraps, direction reversals and
// jumps as one-cycle pulses, and keeps a saturating tally of jumps.
//
// Ports
//   clk        : clock, rising edge
//   r          : asynchronous active-low reset
//   sample     : qualifies `count` this cycle (tie to the counter enable)
//   count      : observed counter value, N bits
//   state      : 00 EMPTY, 01 STILL, 10 UP, 11 DOWN
//   wrap       : pulse on a modular wrap step (max->0 up, 0->max down)
//   jump       : pulse on a non-unit, non-zero step
//   dir_change : pulse on a direct UP<->DOWN reversal
//   jump_cnt   : saturating count of jumps since reset, JW bits
//
// state  | meaning
// -------+----------------------------------------------------------
// EMPTY  | no valid history; the next sample only primes prev
// STILL  | last transition was a hold or a jump, or priming just ran
// UP     | last transition was a +1 step
// DOWN   | last transition was a -1 step

module count_sequence_monitor #(
    parameter int N  = 3,
    parameter int JW = 8
) (
    input  logic          clk,
    input  logic          r,
    input  logic          sample,
    input  logic [N-1:0]  count,
    output logic [1:0]    state,
    output logic          wrap,
    output logic          jump,
    output logic          dir_change,
    output logic [JW-1:0] jump_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        STILL = 2'b01,
        UP    = 2'b10,
        DOWN  = 2'b11
    } state_t;

    localparam logic [N-1:0]  ZERO_N = '0;
    localparam logic [N-1:0]  ONE_N  = N'(1);
    localparam logic [N-1:0]  MAX_N  = '1;
    localparam logic [JW-1:0] MAX_JW = '1;
    localparam logic [JW-1:0] ONE_JW = JW'(1);

    state_t        state_q, state_d;
    logic [N-1:0]  prev_q, prev_d;
    logic          wrap_q, wrap_d;
    logic          jump_q, jump_d;
    logic          dir_q, dir_d;
    logic [JW-1:0] jump_cnt_q, jump_cnt_d;

    // Modular difference; the carry out of the N-bit subtract is dropped
    // on purpose, which makes max->0 read as +1 and 0->max read as -1.
    logic [N-1:0]  delta;
    logic          is_hold;
    logic          is_up;
    logic          is_down;

    assign delta   = count - prev_q;
    assign is_hold = (delta == ZERO_N);
    assign is_up   = (delta == ONE_N);
    assign is_down = (delta == MAX_N);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        jump_cnt_d = jump_cnt_q;
        wrap_d     = 1'b0;
        jump_d     = 1'b0;
        dir_d      = 1'b0;

        if (sample) begin
            prev_d = count;
            if (state_q == EMPTY) begin
                // Priming only: there is no history to classify against.
                state_d = STILL;
            end else if (is_hold) begin
                state_d = STILL;
            end else if (is_up) begin
                state_d = UP;
                wrap_d  = (prev_q == MAX_N);
                dir_d   = (state_q == DOWN);
            end else if (is_down) begin
                state_d = DOWN;
                wrap_d  = (prev_q == ZERO_N);
                dir_d   = (state_q == UP);
            end else begin
                state_d = STILL;
                jump_d  = 1'b1;
                if (jump_cnt_q != MAX_JW) begin
                    jump_cnt_d = jump_cnt_q + ONE_JW;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q    <= EMPTY;
            prev_q     <= '0;
            wrap_q     <= 1'b0;
            jump_q     <= 1'b0;
            dir_q      <= 1'b0;
            jump_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            wrap_q     <= wrap_d;
            jump_q     <= jump_d;
            dir_q      <= dir_d;
            jump_cnt_q <= jump_cnt_d;
        end
    end

    assign state      = state_q;
    assign wrap       = wrap_q;
    assign jump       = jump_q;
    assign dir_change = dir_q;
    assign jump_cnt   = jump_cnt_q;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Directed bench for count_sequence_monitor with N=3, JW=2.
module tb_count_sequence_monitor;

    localparam int N  = 3;
    localparam int JW = 2;

    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_STILL = 2'b01;
    localparam logic [1:0] S_UP    = 2'b10;
    localparam logic [1:0] S_DOWN  = 2'b11;

    logic          clk;
    logic          r;
    logic          sample;
    logic [N-1:0]  count;
    logic [1:0]    state;
    logic          wrap;
    logic          jump;
    logic          dir_change;
    logic [JW-1:0] jump_cnt;

    int n_vec;
    int n_err;

    count_sequence_monitor #(.N(N), .JW(JW)) dut (
        .clk        (clk),
        .r          (r),
        .sample     (sample),
        .count      (count),
        .state      (state),
        .wrap       (wrap),
        .jump       (jump),
        .dir_change (dir_change),
        .jump_cnt   (jump_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic w,
                           input logic j, input logic d, input logic [JW-1:0] jc);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
        chk({tag, ".jump"}, 32'(jump), 32'(j));
        chk({tag, ".dir"}, 32'(dir_change), 32'(d));
        chk({tag, ".jcnt"}, 32'(jump_cnt), 32'(jc));
    endtask

    // Drive inputs 1 time unit after a rising edge, sample 1 after the next.
    task automatic step(input logic s, input logic [N-1:0] c);
        sample = s;
        count  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sample = 1'b0;
        r = 1'b0;
        #3;
        r = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        sample = 1'b0;
        count  = '0;
        r      = 1'b0;
        #7;
        chk_all("reset", S_EMPTY, 0, 0, 0, 0);
        r = 1'b1;
        @(posedge clk);
        #1;
        chk_all("idle_after_reset", S_EMPTY, 0, 0, 0, 0);

        // Count up 0..7 then 0.
        step(1, 3'd0);
        chk_all("up_prime", S_STILL, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            step(1, 3'(i));
            chk_all($sformatf("up_%0d", i), S_UP, 0, 0, 0, 0);
        end
        step(1, 3'd0);
        chk_all("up_wrap", S_UP, 1, 0, 0, 0);
        step(0, 3'd4);
        chk_all("up_gap", S_UP, 0, 0, 0, 0);

        // Count down 2,1,0,7.
        do_reset();
        step(1, 3'd2);
        chk_all("dn_prime", S_STILL, 0, 0, 0, 0);
        step(1, 3'd1);
        chk_all("dn_1", S_DOWN, 0, 0, 0, 0);
        step(1, 3'd0);
        chk_all("dn_0", S_DOWN, 0, 0, 0, 0);
        step(1, 3'd7);
        chk_all("dn_wrap", S_DOWN, 1, 0, 0, 0);

        // Reversal 3,4,3.
        do_reset();
        step(1, 3'd3);
        step(1, 3'd4);
        chk_all("rev_up", S_UP, 0, 0, 0, 0);
        step(1, 3'd3);
        chk_all("rev_dn", S_DOWN, 0, 0, 1, 0);
        step(1, 3'd4);
        chk_all("rev_up2", S_UP, 0, 0, 1, 0);

        // STILL then step is not a reversal: 3,3,4.
        do_reset();
        step(1, 3'd3);
        step(1, 3'd3);
        chk_all("still_hold", S_STILL, 0, 0, 0, 0);
        step(1, 3'd4);
        chk_all("still_up", S_UP, 0, 0, 0, 0);

        // Simultaneous wrap and reversal: 7,0 (UP wrap) then 7 (DOWN wrap).
        do_reset();
        step(1, 3'd7);
        step(1, 3'd0);
        chk_all("sim_up", S_UP, 1, 0, 0, 0);
        step(1, 3'd7);
        chk_all("sim_dn", S_DOWN, 1, 0, 1, 0);

        // Jumps with saturation at 3 (JW=2).
        do_reset();
        step(1, 3'd2);
        step(1, 3'd6);
        chk_all("jmp_1", S_STILL, 0, 1, 0, 1);
        step(1, 3'd2);
        chk_all("jmp_2", S_STILL, 0, 1, 0, 2);
        step(1, 3'd0);
        chk_all("jmp_3", S_STILL, 0, 1, 0, 3);
        step(1, 3'd5);
        chk_all("jmp_sat4", S_STILL, 0, 1, 0, 3);
        step(1, 3'd1);
        chk_all("jmp_sat5", S_STILL, 0, 1, 0, 3);
        step(1, 3'd2);
        chk_all("jmp_then_up", S_UP, 0, 0, 0, 3);

        // Gating: count moves while sample=0; prev stays 5.
        do_reset();
        step(1, 3'd5);
        for (int i = 1; i <= 5; i++) begin
            step(0, 3'(i));
            chk_all($sformatf("gate_%0d", i), S_STILL, 0, 0, 0, 0);
        end
        step(1, 3'd5);
        chk_all("gate_resume", S_STILL, 0, 0, 0, 0);

        // Mid-run reset kills a live wrap pulse without a clock edge.
        do_reset();
        step(1, 3'd6);
        step(1, 3'd7);
        step(1, 3'd0);
        chk_all("mid_pre", S_UP, 1, 0, 0, 0);
        #2;
        r = 1'b0;
        #1;
        chk_all("mid_async", S_EMPTY, 0, 0, 0, 0);
        #1;
        r = 1'b1;
        sample = 1'b1;
        count  = 3'd7;
        @(posedge clk);
        #1;
        chk_all("mid_prime", S_STILL, 0, 0, 0, 0);
        step(1, 3'd0);
        chk_all("mid_wrap", S_UP, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_sequence_monitor.md
# count_sequence_monitor

Receive-side companion to the loadable up/down counter. It samples the counter's `count` bus whenever the counter's output is qualified. It classifies each transition as hold, up-step, down-step or jump (load), and tracks direction in a small state machine. It reports wrap-around and direction reversals as single-cycle pulses and keeps a saturating tally of jumps, so benches and downstream logic can check a counter's behaviour without re-modelling it.

## Interface
- `N`, default 3: width of the observed count. Legal values are N >= 2, so that +1 and -1 modulo 2^N are distinct.
- `JW`, default 8: width of the jump tally.

Ports:
- `clk`, input, 1 bit: clock; all state changes on the rising edge.
- `r`, input, 1 bit: reset. Asynchronous, active-low.
- `sample`, input, 1 bit: qualifies `count` this cycle. Tie it to the counter's enable.
- `count`, input, N bits: observed counter value.
- `state`, output, 2 bits: 00 EMPTY, 01 STILL, 10 UP, 11 DOWN.
- `wrap`, output, 1 bit: one-cycle pulse on a modular wrap step.
- `jump`, output, 1 bit: one-cycle pulse on a non-unit, non-zero step.
- `dir_change`, output, 1 bit: one-cycle pulse on a direct UP<->DOWN reversal.
- `jump_cnt`, output, JW bits: saturating count of jumps since reset.

## Operation
- Internal `prev[N-1:0]` holds the last sampled value. `delta = (count - prev) mod 2^N`, computed at N bits with carry discarded.
- `sample` = 0: `prev`, `state` and `jump_cnt` hold; `wrap`, `jump` and `dir_change` are 0 in the next cycle.
- `sample` = 1 in EMPTY: `prev <= count`, state -> STILL, no pulses. This is priming only.
- `sample` = 1 in any other state, classified by delta:
  - delta = 0: state -> STILL, no pulses.
  - delta = 1 (up-step): state -> UP. `wrap` = 1 iff prev = 2^N-1. `dir_change` = 1 iff the current state is DOWN.
  - delta = 2^N-1 (down-step): state -> DOWN. `wrap` = 1 iff prev = 0. `dir_change` = 1 iff the current state is UP.
  - any other delta: state -> STILL, `jump` = 1, `jump_cnt` increments unless already 2^JW-1, in which case it holds.
  - In every case `prev <= count`.
- STILL followed by a step is not a reversal: `dir_change` = 0.
- Simultaneous events are allowed: `wrap` and `dir_change` can both assert on the same step, e.g. UP at 0, then 7 with N=3.
- `jump` never coincides with `wrap` or `dir_change`.

## Timing
- All outputs are registered. Classification of a sample taken at edge k appears after edge k and lasts exactly one cycle, unless edge k+1 produces another event.
- Latency from a `count` change to the response is 1 clock. Back-to-back samples are accepted every cycle with no stalls.
- Reset values while `r` = 0: `state` = EMPTY (00), `prev` = 0, `wrap` = `jump` = `dir_change` = 0, `jump_cnt` = 0. All are cleared immediately, independent of `clk`.
- Reset asserted mid-operation: any in-flight pulse is killed at once.
- After `r` deasserts, the first `sample` = 1 only primes. No event can be reported against pre-reset history.
- `count` needs to be stable only around the rising edge on which `sample` = 1.

## Test plan
- Count-up with wrap: reset, then sample 0,1,...,7,0 on consecutive cycles with N=3.
  - After the 2nd sample: state = UP.
  - `wrap` pulses once, on the 7->0 sample only.
  - `jump`, `dir_change` and `jump_cnt` stay 0.
- Count-down with wrap: sample 2,1,0,7.
  - State DOWN from the 2nd sample on.
  - `wrap` pulses on 0->7 only.
- Reversal: sample 3,4,3.
  - State UP, then DOWN, with `dir_change` = 1 on the third sample.
  - Variant 3,3,4: `dir_change` stays 0 (STILL->UP).
- Jump and saturation: sample 2 then 6.
  - `jump` = 1, state = STILL, `jump_cnt` = 1.
  - With JW=2, apply 5 jumps: `jump_cnt` sticks at 3.
- Gating: hold `sample` = 0 while `count` moves 1->5, then sample 5 (prev = 5 from before the gap).
  - No pulses. State becomes STILL.
- Mid-run reset: during an up-count, pull `r` low between clock edges.
  - `state` = 00 and all pulses 0 without waiting for `clk`.
  - After release, samples 7 then 0 give no `wrap` on the first sample (prime), and `wrap` = 1 only when the next step 7->0 follows.
